// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the descriptor sequencer:
//   - one-hot FSM state encoding (9 states)
//   - descriptor ACT codes and word0 attribute/field bit positions
//   - byte offsets of the three descriptor words that are fetched
// -----------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [8:0] {
    S_IDLE      = 9'b0_0000_0001,
    S_FETCH0    = 9'b0_0000_0010,
    S_FETCH1    = 9'b0_0000_0100,
    S_FETCH2    = 9'b0_0000_1000,
    S_DECODE    = 9'b0_0001_0000,
    S_LAUNCH    = 9'b0_0010_0000,
    S_WAIT_XFER = 9'b0_0100_0000,
    S_FINISH    = 9'b0_1000_0000,
    S_ERR       = 9'b1_0000_0000
  } state_t;

  // ACT field of word0
  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSVD = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  // word0 bit positions
  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned END_BIT   = 1;
  localparam int unsigned INT_BIT   = 2;
  localparam int unsigned ACT_LSB   = 4;
  localparam int unsigned LEN_LSB   = 16;

  // Byte offsets of the fetched descriptor words (word3 is never read)
  localparam logic [63:0] WORD0_OFS = 64'd0;
  localparam logic [63:0] WORD1_OFS = 64'd4;
  localparam logic [63:0] WORD2_OFS = 64'd8;

endpackage

// File: rtl/dma_desc_decode.sv
// -----------------------------------------------------------------------------
// dma_desc_decode
// Combinational field extraction from descriptor word0.
// Ports:
//   word0    in  32  descriptor control word
//   is_valid out 1   VALID attribute
//   is_end   out 1   END attribute
//   is_int   out 1   INT attribute
//   act      out 2   action code (NOP/TRAN/LINK/reserved)
//   length   out 16  transfer length in 32-bit words
// -----------------------------------------------------------------------------
module dma_desc_decode
  import dma_pkg::*;
(
  input  logic [31:0] word0,
  output logic        is_valid,
  output logic        is_end,
  output logic        is_int,
  output logic [1:0]  act,
  output logic [15:0] length
);

  // Bits [3] and [15:6] carry no meaning for the sequencer.
  logic unused_bits_s;
  assign unused_bits_s = ^{word0[15:6], word0[3]};

  assign is_valid = word0[VALID_BIT];
  assign is_end   = word0[END_BIT];
  assign is_int   = word0[INT_BIT];
  assign act      = word0[ACT_LSB +: 2];
  assign length   = word0[LEN_LSB +: 16];

endmodule

// File: rtl/dma_desc_sequencer.sv
// -----------------------------------------------------------------------------
// dma_desc_sequencer
// Walks a descriptor table in system RAM, fetching three words per
// descriptor, and programs/launches the FIFO<->RAM transfer engine until an
// END descriptor, an error (invalid descriptor / loop guard) or an abort.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, stop           run pulse (IDLE only), abort level
//   direction, desc_base  run parameters, sampled on an accepted start
//   ram_read, ram_adress  descriptor fetch strobe and byte address
//   data_from_ram         fetch data, valid the cycle after ram_read
//   xfer_start/_direction/_address/_length   transfer engine programming
//   xfer_done             transfer completion pulse from the engine
//   busy, done, error, int_pulse             host status
// All outputs are registered.
// -----------------------------------------------------------------------------
module dma_desc_sequencer
  import dma_pkg::*;
#(
  parameter int unsigned MAX_DESC    = 256,
  parameter int unsigned DESC_STRIDE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        direction,
  input  logic [63:0] desc_base,
  output logic        ram_read,
  output logic [63:0] ram_adress,
  input  logic [31:0] data_from_ram,
  output logic        xfer_start,
  output logic        xfer_direction,
  output logic [63:0] xfer_address,
  output logic [15:0] xfer_length,
  input  logic        xfer_done,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        int_pulse
);

  // Counter must hold MAX_DESC+1 because it also advances on the DECODE
  // cycle that trips the loop guard.
  localparam int unsigned      CNT_W   = $clog2(MAX_DESC + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DESC);
  localparam logic [63:0]      STRIDE  = 64'(DESC_STRIDE);

  state_t            state_r;
  logic              phase_r;      // 0: read issue cycle, 1: data capture cycle
  logic [63:0]       ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              dir_r;
  logic [31:0]       word0_r;
  logic [31:0]       word1_r;
  logic [31:0]       word2_r;
  logic              stop_pend_r;  // abort seen while the engine is busy

  logic              dec_valid_s;
  logic              dec_end_s;
  logic              dec_int_s;
  logic [1:0]        dec_act_s;
  logic [15:0]       dec_len_s;
  logic [63:0]       desc_addr_s;
  logic [63:0]       next_ptr_s;

  dma_desc_decode u_decode (
    .word0    (word0_r),
    .is_valid (dec_valid_s),
    .is_end   (dec_end_s),
    .is_int   (dec_int_s),
    .act      (dec_act_s),
    .length   (dec_len_s)
  );

  assign desc_addr_s = {word2_r, word1_r};
  assign next_ptr_s  = ptr_r + STRIDE;   // wraps modulo 2^64 by width

  // Sequencer FSM with all outputs registered; pulse outputs default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      phase_r        <= 1'b0;
      ptr_r          <= 64'd0;
      count_r        <= {CNT_W{1'b0}};
      dir_r          <= 1'b0;
      word0_r        <= 32'd0;
      word1_r        <= 32'd0;
      word2_r        <= 32'd0;
      stop_pend_r    <= 1'b0;
      ram_read       <= 1'b0;
      ram_adress     <= 64'd0;
      xfer_start     <= 1'b0;
      xfer_direction <= 1'b0;
      xfer_address   <= 64'd0;
      xfer_length    <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      int_pulse      <= 1'b0;
    end else begin
      ram_read   <= 1'b0;
      xfer_start <= 1'b0;
      done       <= 1'b0;
      int_pulse  <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (start) begin
            ptr_r       <= desc_base;
            dir_r       <= direction;
            error       <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            stop_pend_r <= 1'b0;
            busy        <= 1'b1;
            phase_r     <= 1'b0;
            state_r     <= S_FETCH0;
            ram_read    <= 1'b1;
            ram_adress  <= desc_base + WORD0_OFS;
          end
        end

        S_FETCH0, S_FETCH1, S_FETCH2: begin
          if (stop) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            phase_r <= 1'b0;
          end else if (!phase_r) begin
            phase_r <= 1'b1;
          end else begin
            phase_r <= 1'b0;
            case (state_r)
              S_FETCH0: begin
                word0_r    <= data_from_ram;
                state_r    <= S_FETCH1;
                ram_read   <= 1'b1;
                ram_adress <= ptr_r + WORD1_OFS;
              end
              S_FETCH1: begin
                word1_r    <= data_from_ram;
                state_r    <= S_FETCH2;
                ram_read   <= 1'b1;
                ram_adress <= ptr_r + WORD2_OFS;
              end
              default: begin
                word2_r <= data_from_ram;
                state_r <= S_DECODE;
              end
            endcase
          end
        end

        S_DECODE: begin
          count_r <= count_r + CNT_W'(1);
          if (stop) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else if (!dec_valid_s || (dec_act_s == ACT_RSVD)) begin
            state_r <= S_ERR;
            error   <= 1'b1;
          end else if (count_r == CNT_MAX) begin
            state_r <= S_ERR;
            error   <= 1'b1;
          end else if (dec_act_s == ACT_LINK) begin
            // END is deliberately ignored on a link
            ptr_r      <= desc_addr_s;
            state_r    <= S_FETCH0;
            ram_read   <= 1'b1;
            ram_adress <= desc_addr_s + WORD0_OFS;
          end else if ((dec_act_s == ACT_NOP) || (dec_len_s == 16'd0)) begin
            if (dec_end_s) begin
              state_r <= S_FINISH;
              done    <= 1'b1;
            end else begin
              ptr_r      <= next_ptr_s;
              state_r    <= S_FETCH0;
              ram_read   <= 1'b1;
              ram_adress <= next_ptr_s + WORD0_OFS;
            end
          end else begin
            state_r        <= S_LAUNCH;
            xfer_start     <= 1'b1;
            xfer_address   <= desc_addr_s;
            xfer_length    <= dec_len_s;
            xfer_direction <= dir_r;
          end
        end

        S_LAUNCH: begin
          if (stop) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= S_WAIT_XFER;
          end
        end

        // The engine cannot be cancelled: an abort is remembered and acted
        // on only once the transfer completes.
        S_WAIT_XFER: begin
          stop_pend_r <= stop_pend_r | stop;
          if (xfer_done) begin
            int_pulse <= dec_int_s;
            if (stop || stop_pend_r) begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end else if (dec_end_s) begin
              state_r <= S_FINISH;
              done    <= 1'b1;
            end else begin
              ptr_r      <= next_ptr_s;
              state_r    <= S_FETCH0;
              ram_read   <= 1'b1;
              ram_adress <= next_ptr_s + WORD0_OFS;
            end
          end
        end

        S_FINISH, S_ERR: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          phase_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dma_desc_sequencer
// Scoreboard bench: each directed test pushes its expected fetch addresses,
// transfer programming, int and done events into queues; a monitor pops and
// compares whenever the DUT strobes the corresponding output. A RAM model
// and a transfer-engine model respond to the DUT. Inputs change at
// posedge+1; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_desc_sequencer;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] len;
    logic        dir;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        direction;
  logic [63:0] desc_base;
  logic        ram_read;
  logic [63:0] ram_adress;
  logic [31:0] data_from_ram;
  logic        xfer_start;
  logic        xfer_direction;
  logic [63:0] xfer_address;
  logic [15:0] xfer_length;
  logic        xfer_done;
  logic        busy;
  logic        done;
  logic        error;
  logic        int_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_xd_cyc = 0;
  int eng_lat = 3;

  logic [31:0] mem [logic [63:0]];
  logic [63:0] exp_rd_q [$];
  xfer_t       exp_xfer_q [$];
  int          exp_int_q [$];   // expected gap after xfer_done
  int          exp_done_q [$];  // expected gap after xfer_done, -1 = any

  dma_desc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .direction      (direction),
    .desc_base      (desc_base),
    .ram_read       (ram_read),
    .ram_adress     (ram_adress),
    .data_from_ram  (data_from_ram),
    .xfer_start     (xfer_start),
    .xfer_direction (xfer_direction),
    .xfer_address   (xfer_address),
    .xfer_length    (xfer_length),
    .xfer_done      (xfer_done),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .int_pulse      (int_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] v);
    tests++;
    fails++;
    $display("FAIL %s: unexpected strobe (value %0h), expected none", name, v);
  endtask

  // RAM model: answer a fetch strobe; data stays put through the capture cycle.
  initial begin
    data_from_ram = 32'd0;
    forever begin
      @(negedge clk);
      if (ram_read === 1'b1)
        data_from_ram = mem.exists(ram_adress) ? mem[ram_adress] : 32'd0;
    end
  end

  // Transfer engine model: completes eng_lat cycles after each launch.
  initial begin
    xfer_done = 1'b0;
    forever begin
      @(negedge clk);
      if (xfer_start === 1'b1) begin
        repeat (eng_lat) @(posedge clk);
        #1 xfer_done = 1'b1;
        @(posedge clk);
        #1 xfer_done = 1'b0;
      end
    end
  end

  // Monitor: pop and compare on every output strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (xfer_done === 1'b1) last_xd_cyc = cyc;
      if (ram_read === 1'b1) begin
        if (exp_rd_q.size() == 0) unexpected("ram_read", ram_adress);
        else chk("ram_adress", ram_adress, exp_rd_q.pop_front());
      end
      if (xfer_start === 1'b1) begin
        if (exp_xfer_q.size() == 0) unexpected("xfer_start", xfer_address);
        else begin
          xfer_t e;
          e = exp_xfer_q.pop_front();
          chk("xfer_address", xfer_address, e.addr);
          chk("xfer_length", 64'(xfer_length), 64'(e.len));
          chk("xfer_direction", 64'(xfer_direction), 64'(e.dir));
        end
      end
      if (int_pulse === 1'b1) begin
        if (exp_int_q.size() == 0) unexpected("int_pulse", 64'd1);
        else chk("int_gap", 64'(cyc - last_xd_cyc), 64'(exp_int_q.pop_front()));
      end
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) unexpected("done", 64'd1);
        else begin
          int g;
          g = exp_done_q.pop_front();
          if (g >= 0) chk("done_gap", 64'(cyc - last_xd_cyc), 64'(g));
        end
      end
    end
  end

  task automatic do_start(input logic [63:0] base, input logic dir);
    @(posedge clk);
    #1;
    desc_base = base;
    direction = dir;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int at_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, budget);
    end
    at_cyc = cyc;
  endtask

  task automatic wait_launch(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (xfer_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (xfer_start !== 1'b1) begin
      fails++;
      $display("FAIL %s: xfer_start %b after %0d cycles, expected 1", name, xfer_start, budget);
    end
  endtask

  task automatic drained(input string name);
    chk({name, "_rd_left"},   64'(exp_rd_q.size()),   64'd0);
    chk({name, "_xfer_left"}, 64'(exp_xfer_q.size()), 64'd0);
    chk({name, "_int_left"},  64'(exp_int_q.size()),  64'd0);
    chk({name, "_done_left"}, 64'(exp_done_q.size()), 64'd0);
  endtask

  task automatic push_reads(input logic [63:0] base);
    exp_rd_q.push_back(base);
    exp_rd_q.push_back(base + 64'd4);
    exp_rd_q.push_back(base + 64'd8);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    direction = 1'b0;
    desc_base = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // ---- reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_ram_read", 64'(ram_read), 64'd0);
    chk("rst_ram_adress", ram_adress, 64'd0);
    chk("rst_xfer_start", 64'(xfer_start), 64'd0);
    chk("rst_xfer_address", xfer_address, 64'd0);
    chk("rst_xfer_length", 64'(xfer_length), 64'd0);
    chk("rst_int", 64'(int_pulse), 64'd0);

    // ---- 1: single TRAN+END, len 16 at 0x1000
    mem[64'h100] = 32'h0010_0023; mem[64'h104] = 32'h0000_1000; mem[64'h108] = 32'h0;
    push_reads(64'h100);
    exp_xfer_q.push_back('{addr: 64'h1000, len: 16'd16, dir: 1'b0});
    exp_done_q.push_back(1);
    do_start(64'h100, 1'b0);
    wait_idle("t1_idle", 200, t);
    chk("t1_error", 64'(error), 64'd0);
    drained("t1");

    // ---- 2: two TRANs, second END+INT, direction 1, 64-bit address; start while busy ignored
    mem[64'h100] = 32'h0004_0021; mem[64'h104] = 32'h0000_3000; mem[64'h108] = 32'h0000_0001;
    mem[64'h110] = 32'h0008_0027; mem[64'h114] = 32'h0000_4000; mem[64'h118] = 32'h0;
    push_reads(64'h100);
    push_reads(64'h110);
    exp_xfer_q.push_back('{addr: 64'h1_0000_3000, len: 16'd4, dir: 1'b1});
    exp_xfer_q.push_back('{addr: 64'h4000, len: 16'd8, dir: 1'b1});
    exp_int_q.push_back(1);
    exp_done_q.push_back(1);
    do_start(64'h100, 1'b1);
    wait_launch("t2_launch", 100);
    do_start(64'h900, 1'b0);
    wait_idle("t2_idle", 300, t);
    chk("t2_error", 64'(error), 64'd0);
    drained("t2");

    // ---- 3: LINK to 0x2000, then TRAN+END
    mem[64'h100] = 32'h0000_0031; mem[64'h104] = 32'h0000_2000; mem[64'h108] = 32'h0;
    mem[64'h2000] = 32'h0002_0023; mem[64'h2004] = 32'h0000_5000; mem[64'h2008] = 32'h0;
    push_reads(64'h100);
    push_reads(64'h2000);
    exp_xfer_q.push_back('{addr: 64'h5000, len: 16'd2, dir: 1'b0});
    exp_done_q.push_back(1);
    do_start(64'h100, 1'b0);
    wait_idle("t3_idle", 300, t);
    chk("t3_error", 64'(error), 64'd0);
    drained("t3");

    // ---- 4: VALID=0 -> sticky error; NOP+END restart clears it
    mem[64'h100] = 32'h0004_0020;
    push_reads(64'h100);
    do_start(64'h100, 1'b0);
    wait_idle("t4_idle", 200, t);
    chk("t4_error_set", 64'(error), 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_error_sticky", 64'(error), 64'd1);
    mem[64'h200] = 32'h0000_0003; mem[64'h204] = 32'h0; mem[64'h208] = 32'h0;
    push_reads(64'h200);
    exp_done_q.push_back(-1);
    do_start(64'h200, 1'b0);
    @(negedge clk);
    chk("t4_error_cleared", 64'(error), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    wait_idle("t4_idle2", 200, t);
    chk("t4_error_after", 64'(error), 64'd0);
    drained("t4");

    // ---- 5: self LINK -> loop guard after MAX_DESC decodes, no launch
    mem[64'h300] = 32'h0000_0031; mem[64'h304] = 32'h0000_0300; mem[64'h308] = 32'h0;
    for (int i = 0; i < 257; i++) push_reads(64'h300);
    do_start(64'h300, 1'b0);
    wait_idle("t5_idle", 4000, t);
    chk("t5_error", 64'(error), 64'd1);
    drained("t5");

    // ---- 6: stop during WAIT_XFER -> IDLE right after xfer_done, INT honoured, no done
    eng_lat = 8;
    mem[64'h100] = 32'h0010_0027; mem[64'h104] = 32'h0000_1000; mem[64'h108] = 32'h0;
    push_reads(64'h100);
    exp_xfer_q.push_back('{addr: 64'h1000, len: 16'd16, dir: 1'b0});
    exp_int_q.push_back(1);
    do_start(64'h100, 1'b0);
    wait_launch("t6_launch", 100);
    @(posedge clk);
    #1 stop = 1'b1;
    @(negedge clk);
    chk("t6_still_busy", 64'(busy), 64'd1);
    wait_idle("t6_idle", 100, t);
    chk("t6_idle_gap", 64'(t - last_xd_cyc), 64'd1);
    chk("t6_error", 64'(error), 64'd0);
    @(posedge clk);
    #1 stop = 1'b0;
    eng_lat = 3;
    drained("t6");

    // ---- 7: reset during FETCH1 -> all outputs 0 next cycle
    mem[64'h100] = 32'h0010_0023; mem[64'h104] = 32'h0000_1000; mem[64'h108] = 32'h0;
    exp_rd_q.push_back(64'h100);
    exp_rd_q.push_back(64'h104);
    do_start(64'h100, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_ram_read", 64'(ram_read), 64'd0);
    chk("t7_ram_adress", ram_adress, 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_error", 64'(error), 64'd0);
    chk("t7_xfer_start", 64'(xfer_start), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    drained("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
